// File: rtl/phy_pkg.sv
// Shared PHY definitions: the lane FSM state encoding and the comma/idle symbol.
// Used by both the serial-to-parallel receiver and the parallel-to-serial transmitter.
package phy_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        SYNC   = 2'd1,
        ACTIVE = 2'd2
    } phy_state_t;

    localparam logic [7:0] PHY_COMMA = 8'hBC;

endpackage

// File: rtl/sp_shift_reg.sv
// Serial input shifter and bit counter for the receive lane. It presents the byte
// formed by the incoming bit (nxt) and strobes byte_done on the eighth bit of a byte.
module sp_shift_reg (
    input  logic       clk_8f,
    input  logic       reset,
    input  logic       serial_in,
    input  logic       align,
    output logic [7:0] nxt,
    output logic       byte_done
);

    // nxt always takes the live bit as its LSB, so only the seven most recent
    // stored bits ever reach it; the oldest bit of the 8-bit window is never needed.
    logic [6:0] history;
    logic [2:0] bit_cnt;

    assign nxt       = {history, serial_in};
    assign byte_done = (bit_cnt == 3'd7);

    always_ff @(posedge clk_8f or negedge reset) begin
        if (!reset) begin
            history <= '0;
            bit_cnt <= '0;
        end else begin
            history <= nxt[6:0];
            bit_cnt <= align ? 3'd0 : bit_cnt + 3'd1;
        end
    end

endmodule

// File: rtl/serial_paralelo_rx.sv
// Receive-side serial-to-parallel lane converter: comma hunt, lock after BC_LOCK commas,
// then byte delivery. Define SP_ERR_EN to add the registered err pulse on lock failure.
module serial_paralelo_rx
    import phy_pkg::*;
#(
    parameter logic [7:0] COMMA   = PHY_COMMA,
    parameter int         BC_LOCK = 4
) (
    input  logic       clk_8f,
    input  logic       reset,
    input  logic       serial_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active
`ifdef SP_ERR_EN
    ,
    output logic       err
`endif
);

    localparam logic [4:0] LOCK_TARGET = 5'(BC_LOCK);

    phy_state_t state, state_nxt;
    logic [3:0] comma_cnt, comma_cnt_nxt;
    logic [7:0] data_nxt;
    logic       valid_nxt;
    logic [7:0] nxt;
    logic       byte_done;
    logic       align;
    logic       is_comma;
`ifdef SP_ERR_EN
    logic       err_nxt;
`endif

    sp_shift_reg u_shift (
        .clk_8f    (clk_8f),
        .reset     (reset),
        .serial_in (serial_in),
        .align     (align),
        .nxt       (nxt),
        .byte_done (byte_done)
    );

    assign is_comma = (nxt == COMMA);
    assign active   = (state == ACTIVE);

    always_comb begin
        state_nxt     = state;
        comma_cnt_nxt = comma_cnt;
        data_nxt      = data_out;
        valid_nxt     = valid_out;
        align         = 1'b0;
`ifdef SP_ERR_EN
        err_nxt       = 1'b0;
`endif
        case (state)
            // Hunting is bit-by-bit: any comma window resets byte alignment to it.
            SEARCH: begin
                if (is_comma) begin
                    align         = 1'b1;
                    comma_cnt_nxt = 4'd1;
                    state_nxt     = (LOCK_TARGET == 5'd1) ? ACTIVE : SYNC;
                end
            end
            SYNC: begin
                if (byte_done) begin
                    if (is_comma) begin
                        if (comma_cnt != 4'hF)
                            comma_cnt_nxt = comma_cnt + 4'd1;
                        if (({1'b0, comma_cnt} + 5'd1) == LOCK_TARGET)
                            state_nxt = ACTIVE;
                    end else begin
                        comma_cnt_nxt = 4'd0;
                        state_nxt     = SEARCH;
`ifdef SP_ERR_EN
                        err_nxt       = 1'b1;
`endif
                    end
                end
            end
            ACTIVE: begin
                if (byte_done) begin
                    if (is_comma) begin
                        valid_nxt = 1'b0;
                    end else begin
                        data_nxt  = nxt;
                        valid_nxt = 1'b1;
                    end
                end
            end
            default: state_nxt = SEARCH;
        endcase
    end

    always_ff @(posedge clk_8f or negedge reset) begin
        if (!reset) begin
            state     <= SEARCH;
            comma_cnt <= '0;
            data_out  <= 8'h00;
            valid_out <= 1'b0;
`ifdef SP_ERR_EN
            err       <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            comma_cnt <= comma_cnt_nxt;
            data_out  <= data_nxt;
            valid_out <= valid_nxt;
`ifdef SP_ERR_EN
            err       <= err_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// Directed bench for serial_paralelo_rx: reset, lock timing, offset alignment,
// data/idle delivery, lock failure and asynchronous reset with re-lock.
module tb_serial_paralelo_rx;

    logic       clk_8f = 1'b0;
    logic       reset;
    logic       serial_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;
`ifdef SP_ERR_EN
    logic       err;
`endif

    int checks = 0;
    int errors = 0;

    serial_paralelo_rx dut (
        .clk_8f    (clk_8f),
        .reset     (reset),
        .serial_in (serial_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .active    (active)
`ifdef SP_ERR_EN
        ,
        .err       (err)
`endif
    );

    always #5 clk_8f = ~clk_8f;

    task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are read at that point too.
    task automatic sendBit(input logic b);
        serial_in = b;
        @(posedge clk_8f);
        #1;
    endtask

    task automatic sendByte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) sendBit(b[i]);
    endtask

    task automatic applyReset();
        serial_in = 1'b0;
        reset     = 1'b0;
        repeat (3) @(posedge clk_8f);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        logic [7:0] byte_v;
        logic       rose;

        // Test 1: idle zeros after reset
        applyReset();
        checkOutput("reset_data", data_out, 8'h00);
        checkOutput("reset_valid", {7'd0, valid_out}, 8'h00);
        checkOutput("reset_active", {7'd0, active}, 8'h00);
`ifdef SP_ERR_EN
        checkOutput("reset_err", {7'd0, err}, 8'h00);
`endif
        rose = 1'b0;
        for (int i = 0; i < 64; i++) begin
            sendBit(1'b0);
            if (active || valid_out || data_out != 8'h00) rose = 1'b1;
        end
        checkOutput("zeros_any_output", {7'd0, rose}, 8'h00);

        // Test 2: aligned commas from release, active on edge 32
        applyReset();
        byte_v = 8'hBC;
        for (int i = 0; i < 31; i++) sendBit(byte_v[7 - (i % 8)]);
        checkOutput("lock_edge31_active", {7'd0, active}, 8'h00);
        sendBit(byte_v[0]);
        checkOutput("lock_edge32_active", {7'd0, active}, 8'h01);
        checkOutput("lock_edge32_valid", {7'd0, valid_out}, 8'h00);

        // Test 3: 3-bit offset, then lock and first data byte
        applyReset();
        sendBit(1'b1); sendBit(1'b0); sendBit(1'b1);
        repeat (3) sendByte(8'hBC);
        checkOutput("offset_pre_lock", {7'd0, active}, 8'h00);
        sendByte(8'hBC);
        checkOutput("offset_lock", {7'd0, active}, 8'h01);
        sendByte(8'hA4);
        checkOutput("first_data", data_out, 8'hA4);
        checkOutput("first_valid", {7'd0, valid_out}, 8'h01);

        // Test 4: FF, BC, 32 -- valid holds for the 7 bits before the next byte completes
        byte_v = 8'hFF;
        rose = 1'b0;
        for (int i = 7; i >= 1; i--) begin
            sendBit(byte_v[i]);
            if (!valid_out || data_out != 8'hA4) rose = 1'b1;
        end
        checkOutput("a4_hold_8_cycles", {7'd0, rose}, 8'h00);
        sendBit(byte_v[0]);
        checkOutput("ff_data", data_out, 8'hFF);
        checkOutput("ff_valid", {7'd0, valid_out}, 8'h01);
        sendByte(8'hBC);
        checkOutput("idle_data", data_out, 8'hFF);
        checkOutput("idle_valid", {7'd0, valid_out}, 8'h00);
        checkOutput("idle_active", {7'd0, active}, 8'h01);
        sendByte(8'h32);
        checkOutput("d32_data", data_out, 8'h32);
        checkOutput("d32_valid", {7'd0, valid_out}, 8'h01);

        // Test 5: lock failure from SYNC, then re-lock
        applyReset();
        sendByte(8'hBC);
        sendByte(8'hBC);
        sendByte(8'h55);
        checkOutput("fail_active", {7'd0, active}, 8'h00);
        checkOutput("fail_valid", {7'd0, valid_out}, 8'h00);
`ifdef SP_ERR_EN
        checkOutput("fail_err_pulse", {7'd0, err}, 8'h01);
`endif
        sendBit(1'b1);
`ifdef SP_ERR_EN
        checkOutput("fail_err_clear", {7'd0, err}, 8'h00);
`endif
        byte_v = 8'hBC;
        for (int i = 6; i >= 0; i--) sendBit(byte_v[i]);
        sendByte(8'hBC);
        sendByte(8'hBC);
        checkOutput("relock_3_commas", {7'd0, active}, 8'h00);
        sendByte(8'hBC);
        checkOutput("relock_4_commas", {7'd0, active}, 8'h01);
        sendByte(8'h5A);
        checkOutput("relock_data", data_out, 8'h5A);

        // Test 6: asynchronous reset mid-byte while active
        sendBit(1'b1); sendBit(1'b0); sendBit(1'b1);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async_data", data_out, 8'h00);
        checkOutput("async_valid", {7'd0, valid_out}, 8'h00);
        checkOutput("async_active", {7'd0, active}, 8'h00);
        @(posedge clk_8f);
        #1;
        reset = 1'b1;
        sendByte(8'hBC);
        sendByte(8'hBC);
        sendByte(8'hBC);
        checkOutput("post_reset_3_commas", {7'd0, active}, 8'h00);
        sendByte(8'hBC);
        checkOutput("post_reset_4_commas", {7'd0, active}, 8'h01);
        checkOutput("post_reset_valid", {7'd0, valid_out}, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
